// File: rtl/fright_timer_if.sv
// fright_timer_if: event, level-table and ghost-control signals of the fright timer
interface fright_timer_if;
   logic        frame_tick;
   logic        pause;
   logic        level_clear;
   logic        energizer_eaten;
   logic        ghost_eaten;
   logic [3:0]  fright_time;
   logic [2:0]  fright_flashes;
   logic        fright_active;
   logic        ghost_flash;
   logic        ghost_reverse;
   logic        fright_end;
   logic        points_valid;
   logic [10:0] ghost_points;
   modport master (
      output frame_tick, pause, level_clear, energizer_eaten, ghost_eaten, fright_time, fright_flashes,
      input  fright_active, ghost_flash, ghost_reverse, fright_end, points_valid, ghost_points
   );
   modport slave (
      input  frame_tick, pause, level_clear, energizer_eaten, ghost_eaten, fright_time, fright_flashes,
      output fright_active, ghost_flash, ghost_reverse, fright_end, points_valid, ghost_points
   );
endinterface

// File: rtl/fright_timer.sv
// fright_timer: frightened-mode countdown, end-of-fright flashing and escalating ghost score
module fright_timer #(
   parameter int TICKS_PER_SEC = 60,
   parameter int FLASH_HALF    = 12
) (
   input logic           clk,
   input logic           rst_n,
   fright_timer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FRIGHT, FLASH} state_t;
   localparam logic [15:0] TPS        = 16'(TICKS_PER_SEC);
   localparam logic [15:0] FLASH_SPAN = 16'(2 * FLASH_HALF);
   localparam logic [7:0]  HALF       = 8'(FLASH_HALF);
   state_t      r_state, w_state;
   logic [15:0] r_remaining, w_remaining;
   logic [15:0] r_flash_win, w_flash_win;
   logic [7:0]  r_flash_cnt, w_flash_cnt;
   logic [1:0]  r_combo, w_combo;
   logic        r_active, w_active;
   logic        r_flash, w_flash;
   logic        r_reverse, w_reverse;
   logic        r_end, w_end;
   logic        r_pvalid, w_pvalid;
   logic [10:0] r_points, w_points;
   logic        w_tick, w_armed;
   logic [15:0] w_load_rem, w_load_win, w_rem_dec;
   logic [7:0]  w_cnt_dec;
   assign w_tick     = bus.frame_tick & ~bus.pause;
   assign w_armed    = r_state != IDLE;
   assign w_load_rem = 16'(bus.fright_time) * TPS;
   assign w_load_win = 16'(bus.fright_flashes) * FLASH_SPAN;
   assign w_rem_dec  = r_remaining - 16'd1;
   assign w_cnt_dec  = r_flash_cnt - 8'd1;
   // Next state: level_clear wipes everything; a ghost is scored before any same-cycle energizer reload
   always_comb begin
      w_state     = r_state;
      w_remaining = r_remaining;
      w_flash_win = r_flash_win;
      w_flash_cnt = r_flash_cnt;
      w_combo     = r_combo;
      w_flash     = r_flash;
      w_reverse   = 1'b0;
      w_end       = 1'b0;
      w_pvalid    = 1'b0;
      w_points    = r_points;
      if (bus.level_clear) begin
         w_state     = IDLE;
         w_remaining = '0;
         w_flash_win = '0;
         w_flash_cnt = '0;
         w_combo     = '0;
         w_flash     = 1'b0;
         w_points    = '0;
      end else begin
         if (bus.ghost_eaten && w_armed) begin
            w_points = 11'd200 << r_combo;
            w_pvalid = 1'b1;
            w_combo  = (r_combo == 2'd3) ? 2'd3 : r_combo + 2'd1;
         end
         if (bus.energizer_eaten) begin
            w_reverse = 1'b1;
            if (bus.fright_time == 4'd0) begin
               w_state = IDLE;
            end else begin
               w_remaining = w_load_rem;
               w_flash_win = w_load_win;
               w_combo     = 2'd0;
               w_flash_cnt = HALF;
               w_state     = (w_load_win >= w_load_rem) ? FLASH : FRIGHT;
               w_flash     = w_load_win >= w_load_rem;
            end
         end else if (w_tick && w_armed) begin
            w_remaining = w_rem_dec;
            if (w_rem_dec == 16'd0) begin
               w_state = IDLE;
               w_end   = 1'b1;
               w_flash = 1'b0;
            end else if (r_state == FRIGHT && w_rem_dec <= r_flash_win) begin
               w_state     = FLASH;
               w_flash     = 1'b1;
               w_flash_cnt = HALF;
            end else if (r_state == FLASH) begin
               w_flash     = (w_cnt_dec == 8'd0) ? ~r_flash : r_flash;
               w_flash_cnt = (w_cnt_dec == 8'd0) ? HALF : w_cnt_dec;
            end
         end
      end
      w_active = w_state != IDLE;
   end
   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_flash_win <= '0;
         r_flash_cnt <= '0;
         r_combo     <= '0;
         r_active    <= 1'b0;
         r_flash     <= 1'b0;
         r_reverse   <= 1'b0;
         r_end       <= 1'b0;
         r_pvalid    <= 1'b0;
         r_points    <= '0;
      end else begin
         r_state     <= w_state;
         r_remaining <= w_remaining;
         r_flash_win <= w_flash_win;
         r_flash_cnt <= w_flash_cnt;
         r_combo     <= w_combo;
         r_active    <= w_active;
         r_flash     <= w_flash;
         r_reverse   <= w_reverse;
         r_end       <= w_end;
         r_pvalid    <= w_pvalid;
         r_points    <= w_points;
      end
   end
   assign bus.fright_active = r_active;
   assign bus.ghost_flash   = r_flash;
   assign bus.ghost_reverse = r_reverse;
   assign bus.fright_end    = r_end;
   assign bus.points_valid  = r_pvalid;
   assign bus.ghost_points  = r_points;
endmodule

// File: doc/fright_timer.md
# fright_timer

Frightened-mode controller for the ghost subsystem, directly downstream of the per-level parameter table. It consumes the current level's `fright_time` in seconds and `fright_flashes` count, and reacts to energizer and ghost-eaten events from the maze/collision logic. It drives ghost fright state, end-of-fright flashing, direction reversal and the escalating ghost score (200/400/800/1600). All timing is counted in frame ticks.

## Interface
- `TICKS_PER_SEC`, default 60: frame ticks per second of `fright_time`.
- `FLASH_HALF`, default 12: frame ticks per half flash period (white or blue phase).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `pause` in 1: while high, frame ticks are ignored (used during the ghost-eaten freeze and death animation).
- `level_clear` in 1: synchronous cancel at level start or Pac-Man death.
- `energizer_eaten` in 1: one-cycle pulse.
- `ghost_eaten` in 1: one-cycle pulse; only meaningful while `fright_active`.
- `fright_time` in 4: seconds, from the level table; must be stable at `energizer_eaten`.
- `fright_flashes` in 3: number of flashes, from the level table.
- `fright_active` out 1: ghosts frightened.
- `ghost_flash` out 1: 1 means draw ghosts white, 0 means blue; only meaningful while `fright_active`.
- `ghost_reverse` out 1: one-cycle pulse; ghosts reverse direction.
- `fright_end` out 1: one-cycle pulse when fright expires naturally.
- `points_valid` out 1: one-cycle pulse.
- `ghost_points` out 11: 200/400/800/1600, valid with `points_valid`.

## Operation
- States: IDLE, FRIGHT, FLASH. Internal registers:
  - `remaining`, 16 bits.
  - `flash_win`, 16 bits.
  - `flash_cnt`, 8 bits.
  - `combo`, 2 bits, saturating.
- Energizer in any state:
  - `ghost_reverse` always pulses.
  - If `fright_time` is 0: go to or stay in IDLE. Nothing else changes and `fright_end` does not pulse.
  - Otherwise: load `remaining` = `fright_time`·TICKS_PER_SEC, `flash_win` = `fright_flashes`·2·FLASH_HALF, and clear `combo` to 0.
  - If `flash_win` ≥ `remaining`, enter FLASH directly. Otherwise enter FRIGHT.
  - An energizer during FRIGHT or FLASH reloads in the same way, restarting both the timer and the combo.
- Countdown: on `frame_tick` with `pause` low, in FRIGHT or FLASH, `remaining` decrements by 1.
- Transition to FLASH: from FRIGHT when the post-decrement `remaining` ≤ `flash_win`. On entry, `ghost_flash`=1 and `flash_cnt`=FLASH_HALF.
- Flashing: in FLASH, each counted tick decrements `flash_cnt`. When it reaches 0, toggle `ghost_flash` and reload FLASH_HALF.
- Expiry: when `remaining` reaches 0, go to IDLE, pulse `fright_end`, and clear `ghost_flash`.
- Ghost eaten: `ghost_eaten` in FRIGHT or FLASH sets `ghost_points` = 200 << `combo`, pulses `points_valid`, then increments `combo`, saturating at 3 (1600). It is ignored in IDLE.
- Ghost eaten and energizer in the same cycle: score the ghost with the old `combo`, then apply the energizer reload. The new `combo` is 0.
- `level_clear`: highest priority.
  - State goes to IDLE; all counters and outputs go to 0.
  - No pulses are emitted in that cycle. Any same-cycle energizer or ghost event is dropped.
- Arithmetic: products are computed into 16-bit widths, so there is no overflow for 4-bit × TICKS_PER_SEC ≤ 4095.

## Timing
- All outputs are registered. Reset value of every output is 0, and state is IDLE.
- Energizer at cycle N:
  - `fright_active`=1 and `ghost_reverse`=1 at N+1.
  - `ghost_reverse` is low again at N+2.
- `ghost_eaten` at cycle N: `points_valid` and `ghost_points` appear at N+1. `ghost_points` holds its value until the next score.
- The frame tick that brings `remaining` to 0 at cycle N gives `fright_active`=0 and `fright_end`=1 at N+1.
- The FLASH entry decision and the `ghost_flash` toggle take effect on the cycle after the counted tick.
- `rst_n` asserted mid-fright clears everything immediately (asynchronous). Operation resumes in IDLE after release.

## Test plan
- Level 1 values (`fright_time`=6, `fright_flashes`=5), default parameters, energizer then 360 ticks:
  - `fright_active` is high for exactly 360 ticks.
  - `ghost_flash` rises after tick 240 and toggles after ticks 252, 264 … 348, giving 5 white phases.
  - `fright_end` pulses once, after tick 360.
- Four `ghost_eaten` pulses in fright, then a fifth: `ghost_points` = 200, 400, 800, 1600, 1600.
- `fright_time`=0 (level 17) with energizer: `ghost_reverse` pulses; `fright_active` stays 0; `fright_end` never fires.
- Energizer re-eaten after 300 ticks of a 360-tick fright:
  - The timer reloads to 360 and flashing stops (`ghost_flash`=0, state FRIGHT).
  - The combo resets, so the next ghost scores 200.
- `pause` held for 50 ticks mid-fright: total fright duration is still 360 counted ticks. Simultaneous `ghost_eaten`+`energizer_eaten` with `combo`=2 scores 800, then the next ghost scores 200.
- `level_clear` during FLASH: all outputs are 0 the next cycle and no `fright_end` pulses. Asynchronous `rst_n` pulse mid-fright: same result.
